// File: rtl/display_scan.sv
// Scan sequencer for a 4-digit multiplexed 7-segment message display: digit index,
// blanked message code, frame tick and frame-aligned message update. Optional erro blink: DISPLAY_SCAN_BLINK_EN.
module display_scan #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] msg_code,
  input  logic       msg_valid,
  output logic       msg_ready,
  output logic [1:0] cont,
  output logic [2:0] dis,
  output logic       frame_tick
);

  localparam int            SW        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_LIM = SW'(BLANK_CYCLES);
  localparam logic [1:0]    DIGIT_LAST = 2'b11;
  localparam logic [2:0]    CODE_OFF  = 3'b000;

  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    cont_q, cont_d;
  logic [2:0]    active_q, active_d;
  logic [2:0]    pending_q, pending_d;
  logic          pend_full_q, pend_full_d;
  logic [2:0]    dis_q, dis_d;
  logic          tick_q, tick_d;

  logic          boundary_s;
  logic          accept_s;
  logic          promote_s;
  logic          blank_s;
  logic          blink_off_s;

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    CODE_ERRO  = 3'b100;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;

  // Blink frame counter and phase register
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  // Blink next state: restart on a switch away from erro, count frames while erro shows
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (promote_s && (pending_q != CODE_ERRO)) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if ((active_q == CODE_ERRO) && boundary_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
      blink_off_d = blink_off_q;
    end
  end

  assign blink_off_s = blink_off_d;
`else
  assign blink_off_s = 1'b0;
`endif

  // Scan, handshake and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q      <= '0;
      cont_q      <= 2'b00;
      active_q    <= CODE_OFF;
      pending_q   <= CODE_OFF;
      pend_full_q <= 1'b0;
      dis_q       <= CODE_OFF;
      tick_q      <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      cont_q      <= cont_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      dis_q       <= dis_d;
      tick_q      <= tick_d;
    end
  end

  // Next state; outputs are precomputed from next-state values so they line up with the counters
  always_comb begin
    boundary_s  = (cont_q == DIGIT_LAST) && (slot_q == SLOT_LAST);
    accept_s    = msg_valid && !pend_full_q;
    promote_s   = boundary_s && pend_full_q;

    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      cont_d = cont_q + 2'd1;
    end else begin
      slot_d = slot_q + SW'(1);
      cont_d = cont_q;
    end

    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    if (promote_s) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end else if (accept_s) begin
      pending_d   = msg_code;
      pend_full_d = 1'b1;
    end else begin
      pend_full_d = pend_full_q;
    end

    tick_d  = (cont_d == DIGIT_LAST) && (slot_d == SLOT_LAST);
    blank_s = (slot_d < BLANK_LIM);
    if (blank_s || blink_off_s) begin
      dis_d = CODE_OFF;
    end else begin
      dis_d = active_d;
    end
  end

  assign cont       = cont_q;
  assign dis        = dis_q;
  assign frame_tick = tick_q;
  assign msg_ready  = !pend_full_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: directed scenarios plus random handshake traffic
// compared against a frame-arithmetic reference model.
module tb_display_scan;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DC;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] msg_code = 3'b000;
  logic       msg_valid = 1'b0;
  logic       msg_ready;
  logic [1:0] cont;
  logic [2:0] dis;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int         t = 0;
  logic [2:0] m_active = 3'b000;
  logic [2:0] m_pending = 3'b000;
  logic       m_full = 1'b0;
  int         erro_start = 0;
  logic       last_acc = 1'b0;

  display_scan #(
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .msg_code  (msg_code),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .cont      (cont),
    .dis       (dis),
    .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at t=%0d: got=%0d expected=%0d", tag, t, got, exp);
    end
  endtask

  function automatic int model_dis();
    logic off;
    off = 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
    if (m_active == 3'b100)
      off = (((t / FRAME - erro_start) / BF) % 2) == 1;
`endif
    if ((t % DC) < BC || off) return 0;
    return int'(m_active);
  endfunction

  // one clock cycle: check outputs of cycle t, drive inputs, advance model and DUT
  task automatic step(input logic v, input logic [2:0] c);
    logic boundary;
    check_eq("cont", int'(cont), (t / DC) % 4);
    check_eq("frame_tick", int'(frame_tick), ((t % FRAME) == FRAME - 1) ? 1 : 0);
    check_eq("dis", int'(dis), model_dis());
    msg_valid = v;
    msg_code  = c;
    check_eq("msg_ready", int'(msg_ready), m_full ? 0 : 1);
    last_acc = v && !m_full;
    boundary = (t % FRAME) == FRAME - 1;
    if (boundary && m_full) begin
      if (m_pending == 3'b100 && m_active != 3'b100) erro_start = (t + 1) / FRAME;
      m_active = m_pending;
      m_full   = 1'b0;
    end else if (last_acc) begin
      m_pending = c;
      m_full    = 1'b1;
    end
    @(posedge clock);
    #1;
    t++;
  endtask

  // reset with a live handshake offer that must be overridden
  task automatic do_reset();
    reset     = 1'b1;
    msg_valid = 1'b1;
    msg_code  = 3'b100;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    msg_valid = 1'b0;
    msg_code  = 3'b000;
    t = 0;
    m_active = 3'b000;
    m_pending = 3'b000;
    m_full = 1'b0;
    erro_start = 0;
  endtask

  initial begin
    logic       r_v;
    logic [2:0] r_c;
    logic       done;

    repeat (2) @(posedge clock);
    #1;
    do_reset();
    // idle frames
    for (int i = 0; i < 70; i++) step(1'b0, 3'b000);

    // single offer at cycle 5
    do_reset();
    for (int i = 0; i < 72; i++) step(t == 5, 3'b001);

    // 010 then 011 held while not ready
    do_reset();
    done = 1'b0;
    for (int i = 0; i < 110; i++) begin
      if (t == 2) step(1'b1, 3'b010);
      else if (t > 2 && !done) begin
        step(1'b1, 3'b011);
        done = last_acc;
      end else step(1'b0, 3'b000);
    end

    // offer exactly on the frame boundary
    do_reset();
    for (int i = 0; i < 100; i++) step(t == 31, 3'b011);

    // reset with erro pending
    do_reset();
    for (int i = 0; i < 20; i++) step(t == 3, 3'b100);
    do_reset();
    for (int i = 0; i < 80; i++) step(1'b0, 3'b000);

    // erro blink, switch away, then erro again
    do_reset();
    for (int i = 0; i < 330; i++) begin
      if (t == 0) step(1'b1, 3'b100);
      else if (t == 110) step(1'b1, 3'b001);
      else if (t == 140) step(1'b1, 3'b100);
      else step(1'b0, 3'b000);
    end

    // random traffic, sender holds until accepted, occasional reset
    do_reset();
    r_v = 1'b0;
    r_c = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        r_v = 1'b0;
      end
      if (!r_v && $urandom_range(0, 3) == 0) begin
        r_v = 1'b1;
        r_c = 3'($urandom);
      end
      step(r_v, r_c);
      if (last_acc) r_v = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Scan sequencer for the 4-digit multiplexed 7-segment message display. Generates the digit-select index `cont` and the message code `dis` consumed by the segment/anode decoder. Cycles the four digit positions at a programmable rate with anti-ghosting blanking. Accepts new message codes through a valid/ready handshake and applies them only at frame boundaries, so a message never tears across digits.

## Interface
- `DIGIT_CYCLES`, 50000: clock cycles per digit slot (1 ms at 50 MHz); must be ≥ `BLANK_CYCLES`+1 and ≥ 2.
- `BLANK_CYCLES`, 2: cycles at the start of each slot with `dis` forced to 3'b000 (off).
- `BLINK_FRAMES`, 250: frames per blink half-period (used only with `DISPLAY_SCAN_BLINK_EN`).
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `msg_code` in 3: message code; 001 pare, 010 ocup, 100 erro, 011 siga, any other value displays off.
- `msg_valid` in 1: `msg_code` is offered.
- `msg_ready` out 1: pending slot empty; transfer occurs on `msg_valid && msg_ready`.
- `cont` out 2: digit index to decoder, order 00→01→10→11→00.
- `dis` out 3: message code to decoder.
- `frame_tick` out 1: one-cycle pulse on the last cycle of the digit-11 slot.

## Operation
- Slot counter `slot_cnt`, width $clog2(DIGIT_CYCLES), counts 0..DIGIT_CYCLES-1 then wraps to 0; on wrap `cont` increments mod 4.
- `frame_tick` = 1 when `cont`==11 and `slot_cnt`==DIGIT_CYCLES-1 (the frame boundary).
- Registers: `active` (3 b, drives `dis`), `pending` (3 b), `pend_full` (1 b). `msg_ready` = !`pend_full`.
- Accept: `msg_valid && msg_ready` → `pending`←`msg_code`, `pend_full`←1. Codes are stored unmodified, invalid codes included.
- At frame boundary with `pend_full`=1: `active`←`pending`, `pend_full`←0.
- Acceptance in the boundary cycle itself (pend_full was 0): value goes to `pending`, promoted at the next boundary, not this one.
- `msg_valid` while `msg_ready`=0: ignored, no state change; sender holds.
- `dis` = 3'b000 when `slot_cnt` < BLANK_CYCLES, else `active`. BLANK_CYCLES=0 disables blanking.
- All outputs registered except `msg_ready` (direct from `pend_full`).

## Timing
- Reset values: `cont`=00, `slot_cnt`=0, `dis`=000, `active`=000, `pending`=000, `pend_full`=0, `msg_ready`=1, `frame_tick`=0, blink phase=on, blink counter=0.
- Reset is synchronous and overrides all activity in the same edge, including mid-frame or mid-handshake; a pending message is discarded.
- Frame length = 4·DIGIT_CYCLES cycles; first `frame_tick` at cycle 4·DIGIT_CYCLES-1 after reset release.
- Message latency: `active` updates on the edge ending the boundary cycle; new code visible on `dis` from slot-00 count BLANK_CYCLES onward.
- `msg_ready` rises the cycle after promotion; back-to-back messages therefore accepted at most once per frame.

## Configuration
- `DISPLAY_SCAN_BLINK_EN` defined: when `active`==3'b100 (erro), a frame counter counts `frame_tick`s; every BLINK_FRAMES ticks the blink phase toggles; in off-phase `dis`=000 for the whole frame. Counter and phase reset to 0/on whenever `active` changes to a code other than 100 and on `reset`. Phase changes only at frame boundaries.
- Not defined: no blink logic; erro displayed steadily like every other code.

## Test plan
All with DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset release, no messages → `cont` steps 00,01,10,11 every 8 cycles; `dis`=000 throughout; `frame_tick` at cycles 31, 63.
- Offer 001 at cycle 5 → `msg_ready` low cycle 6; `active`=001 after cycle 31; `dis`=001 at cycles 34–39, 000 at 32–33, `msg_ready` high at cycle 32.
- Offer 010 then hold 011 with valid while not ready → 011 not captured until `msg_ready` rises; 010 shown frame 2, 011 frame 3.
- Offer 011 exactly at cycle 31 (boundary, empty) → not shown in frame 2; shown from cycle 66.
- Assert `reset` at cycle 20 with 100 pending → next cycle all outputs at reset values, `msg_ready`=1, 100 never displayed.
- With `DISPLAY_SCAN_BLINK_EN`, active 100 → two frames with `dis`=100 (after blanking), two frames `dis`=000, repeating; without macro, 100 every frame.
